// File: rtl/comm_rx_demod.sv
// comm_rx_demod: NRZ line receiver. Hysteresis slicer, start/8 data/stop
// framing (LSB first), byte strobe, error strobes and a 16-bit monitor mux.
// Optional feature macro: COMM_RX_PARITY_EN adds an even-parity symbol
// between the data and the stop symbol.
module comm_rx_demod #(
  parameter int          SAMPLES_PER_BIT = 8,
  parameter logic [15:0] HYST            = 16'h0800
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [15:0] sig_from_adc,
  input  logic [1:0]  out_select,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        frame_err,
  output logic        parity_err,
  output logic        busy,
  output logic [15:0] mon_out
);
  localparam int CW = $clog2(SAMPLES_PER_BIT);
  localparam logic [CW-1:0] C_LAST = CW'(SAMPLES_PER_BIT - 1);
  localparam logic [CW-1:0] C_MID  = CW'(SAMPLES_PER_BIT / 2 - 1);
  localparam logic signed [15:0] P_HI = $signed(HYST);
  localparam logic signed [15:0] P_LO = -P_HI;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef COMM_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t         r_state, w_state;
  logic [CW-1:0]  r_cnt, w_cnt;
  logic [2:0]     r_idx, w_idx;
  logic [7:0]     r_shift, w_shift;
  logic [7:0]     r_data, w_data;
  logic           r_dv, w_dv, r_fe, w_fe;
  logic [7:0]     r_good, w_good, r_err, w_err;
  logic           r_slice, r_slice_q;
  logic [15:0]    r_mon;
  logic           w_sample, w_par_bad;

  assign w_sample = (r_cnt == C_LAST);

`ifdef COMM_RX_PARITY_EN
  logic r_par, w_par, r_pe, w_pe;
  // Even parity: data bits plus parity bit must XOR to zero.
  assign w_par_bad  = ^{r_shift, r_par};
  assign parity_err = r_pe;
`else
  assign w_par_bad  = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Slicer with hysteresis; slice holds inside the dead band. The delayed
  // copy gives the 1->0 edge that arms a start.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_slice   <= 1'b1;
      r_slice_q <= 1'b1;
    end else begin
      if ($signed(sig_from_adc) > P_HI)      r_slice <= 1'b1;
      else if ($signed(sig_from_adc) < P_LO) r_slice <= 1'b0;
      r_slice_q <= r_slice;
    end
  end

  // Framer state register and registered strobes/counters.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_dv    <= 1'b0;
      r_fe    <= 1'b0;
      r_good  <= '0;
      r_err   <= '0;
`ifdef COMM_RX_PARITY_EN
      r_par   <= 1'b0;
      r_pe    <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_data  <= w_data;
      r_dv    <= w_dv;
      r_fe    <= w_fe;
      r_good  <= w_good;
      r_err   <= w_err;
`ifdef COMM_RX_PARITY_EN
      r_par   <= w_par;
      r_pe    <= w_pe;
`endif
    end
  end

  // Next-state logic: symbol timing is counted from the mid-start check so
  // every later symbol is sampled near its centre.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt + 1'b1;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_data  = r_data;
    w_dv    = 1'b0;
    w_fe    = 1'b0;
    w_good  = r_good;
    w_err   = r_err;
`ifdef COMM_RX_PARITY_EN
    w_par   = r_par;
    w_pe    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (r_slice_q && !r_slice) w_state = S_START;
      end
      S_START: begin
        if (r_cnt == C_MID) begin
          w_cnt   = '0;
          w_idx   = '0;
          w_state = r_slice ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_sample) begin
          w_cnt          = '0;
          w_shift[r_idx] = r_slice;
          w_idx          = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
`ifdef COMM_RX_PARITY_EN
            w_state = S_PARITY;
`else
            w_state = S_STOP;
`endif
          end
        end
      end
`ifdef COMM_RX_PARITY_EN
      S_PARITY: begin
        if (w_sample) begin
          w_cnt   = '0;
          w_par   = r_slice;
          w_state = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_sample) begin
          w_cnt = '0;
`ifdef COMM_RX_PARITY_EN
          w_pe  = w_par_bad;
`endif
          if (!r_slice) begin
            // Frame error counts once even if parity also failed.
            w_fe    = 1'b1;
            w_err   = r_err + 8'd1;
            w_state = S_BREAK;
          end else begin
            w_state = S_IDLE;
            if (w_par_bad) begin
              w_err = r_err + 8'd1;
            end else begin
              w_data = r_shift;
              w_dv   = 1'b1;
              w_good = r_good + 8'd1;
            end
          end
        end
      end
      S_BREAK: begin
        // A line stuck low must not look like a fresh start edge.
        w_cnt = '0;
        if (r_slice) w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  // Registered debug monitor mux.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_mon <= '0;
    end else begin
      case (out_select)
        2'b00:   r_mon <= {8'h00, r_data};
        2'b01:   r_mon <= {15'b0, r_slice};
        2'b10:   r_mon <= sig_from_adc;
        default: r_mon <= {r_good, r_err};
      endcase
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_dv;
  assign frame_err  = r_fe;
  assign busy       = (r_state != S_IDLE);
  assign mon_out    = r_mon;
endmodule

// File: tb/tb_comm_rx_demod.sv
// Scoreboard bench for comm_rx_demod: frames are generated from bytes, the
// expected strobe of each frame is queued, and a monitor checks every strobe.
`timescale 1ns/1ps
module tb_comm_rx_demod;
  localparam int SPB = 8;
`ifdef COMM_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic [15:0] adc    = 16'h4000;
  logic [1:0]  sel    = 2'b00;
  logic [7:0]  data_out;
  logic        data_valid, frame_err, parity_err, busy;
  logic [15:0] mon_out;

  comm_rx_demod #(.SAMPLES_PER_BIT(SPB), .HYST(16'h0800)) dut (
    .sysclk(sysclk), .reset(reset), .sig_from_adc(adc), .out_select(sel),
    .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err),
    .parity_err(parity_err), .busy(busy), .mon_out(mon_out)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } ev_t;

  ev_t        q[$];
  ev_t        e;
  int         total = 0;
  int         bad   = 0;
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_good = 8'h00;
  logic [7:0] m_err  = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lvl(input logic b);
    int n;
    int v;
    n = int'($urandom_range(0, 2048)) - 1024;
    v = (b ? 16384 : -16384) + n;
    return 16'(v);
  endfunction

  task automatic put(input logic [15:0] v);
    @(posedge sysclk);
    #1 adc = v;
  endtask

  task automatic sym(input logic b, input int n);
    repeat (n) put(lvl(b));
  endtask

  // Reference frame: expected outcome follows directly from the byte, the
  // stop level and the parity choice.
  task automatic send_frame(input logic [7:0] b, input logic stop_bad, input logic pflip);
    ev_t x;
    x.fe = stop_bad;
    x.pe = PAR & pflip;
    if (!x.fe && !x.pe) begin
      m_data = b;
      m_good = m_good + 8'd1;
    end else begin
      m_err = m_err + 8'd1;
    end
    x.d = m_data;
    q.push_back(x);
    sym(1'b0, SPB);
    for (int i = 0; i < 8; i++) sym(b[i], SPB);
    if (PAR) sym((^b) ^ pflip, SPB);
    if (stop_bad) begin
      sym(1'b0, 2 * SPB);
      @(negedge sysclk);
      chk("break_holds_busy", busy, 1);
      sym(1'b1, SPB);
    end else begin
      sym(1'b1, SPB);
    end
  endtask

  task automatic do_reset();
    @(posedge sysclk);
    #1 reset = 1'b1;
    adc = lvl(1'b1);
    repeat (2) put(lvl(1'b1));
    @(posedge sysclk);
    #1 reset = 1'b0;
    m_data = 8'h00;
    m_good = 8'h00;
    m_err  = 8'h00;
    @(negedge sysclk);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_data", data_out, 0);
  endtask

  task automatic check_mon(input string tag);
    sel = 2'b11;
    sym(1'b1, 3);
    @(negedge sysclk);
    chk({tag, "_counts"}, mon_out, {m_good, m_err});
    sel = 2'b00;
    sym(1'b1, 2);
    @(negedge sysclk);
    chk({tag, "_mon_data"}, mon_out, {8'h00, m_data});
    chk({tag, "_idle"}, busy, 0);
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge sysclk) begin
    if (!reset && (data_valid || frame_err || parity_err)) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: dv=%0b fe=%0b pe=%0b data=%0h", data_valid, frame_err, parity_err, data_out);
      end else begin
        e = q.pop_front();
        chk("strobe_data", data_out, e.d);
        chk("strobe_dv", data_valid, (!e.fe && !e.pe));
        chk("strobe_fe", frame_err, e.fe);
        chk("strobe_pe", parity_err, e.pe);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int nb;
    logic [7:0] b;
    logic [15:0] v;
    // 1: reset with the line idle high
    repeat (4) @(posedge sysclk);
    @(negedge sysclk);
    chk("rst_data", data_out, 0);
    chk("rst_strobes", {data_valid, frame_err, parity_err}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mon", mon_out, 0);
    @(posedge sysclk);
    #1 reset = 1'b0;
    sel = 2'b01;
    sym(1'b1, 2);
    @(negedge sysclk);
    chk("rst_slice", mon_out, 1);
    // registered ADC path on the monitor
    sel = 2'b10;
    repeat (3) put(16'h1234);
    @(negedge sysclk);
    chk("mon_adc", mon_out, 16'h1234);

    // 2: back-to-back frames
    sel = 2'b00;
    sym(1'b1, 10);
    send_frame(8'h69, 1'b0, 1'b0);
    send_frame(8'hEF, 1'b0, 1'b0);
    sym(1'b1, 6);
    check_mon("b2b");

    // 3: short glitch, then small noise in the dead band
    sel = 2'b01;
    sym(1'b0, 3);
    bc = 0;
    for (int i = 0; i < 14; i++) begin
      put(lvl(1'b1));
      @(negedge sysclk);
      bc += int'(busy);
    end
    chk("glitch_busy_bounded", (bc >= 1 && bc <= SPB / 2 + 1), 1);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      v = 16'(int'($urandom_range(0, 2048)) - 1024);
      put(v);
      @(negedge sysclk);
      if (mon_out != 16'd1 || busy) nb++;
    end
    chk("noise_slice_hold", nb, 0);
    sym(1'b1, 4);
    check_mon("glitch");

    // 4: stop symbol held low
    send_frame(8'h69, 1'b1, 1'b0);
    sym(1'b1, 6);
    check_mon("frame_err");

    // 5: reset in the middle of data bit 4
    sym(1'b1, 4);
    b = 8'hEF;
    sym(1'b0, SPB);
    for (int i = 0; i < 4; i++) sym(b[i], SPB);
    sym(b[4], 3);
    do_reset();
    sym(1'b1, 10);
    send_frame(8'h69, 1'b0, 1'b0);
    sym(1'b1, 6);
    check_mon("after_reset");

    // 6: parity good then forced bad (only meaningful with parity built in)
    if (PAR) begin
      do_reset();
      sym(1'b1, 6);
      send_frame(8'h69, 1'b0, 1'b0);
      send_frame(8'h69, 1'b0, 1'b1);
      sym(1'b1, 6);
      sel = 2'b11;
      sym(1'b1, 3);
      @(negedge sysclk);
      chk("parity_mon", mon_out, 16'h0101);
    end

    // randomized traffic
    for (int n = 0; n < 30; n++) begin
      send_frame(8'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
      sym(1'b1, int'($urandom_range(0, 12)));
    end
    sym(1'b1, 6);
    check_mon("random");

    sym(1'b1, 20);
    chk("pending_events", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
